// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the rv32 pipe: forwarding selects for E, load-use stall and redirect flush.
// Latency: stall_d/flush_fd are same-cycle combinational; fwd_sel/e_valid depend only on registered state.
// Backpressure: ext_stall freezes all stage state; optional PIPE_HAZARD_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_READY = 2,
    parameter int SELW       = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_use1,
    input  logic              d_use2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_we,
    input  logic              d_load,
    input  logic              e_redirect,
    input  logic              ext_stall,
    output logic              stall_d,
    output logic              flush_fd,
    output logic              e_valid,
    output logic [SELW-1:0]   fwd_sel1,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [SELW-1:0]   fwd_sel2,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`else
    output logic [SELW-1:0]   fwd_sel2
`endif
);

    logic [FWD_DEPTH:0]             valid_q, valid_d;
    logic [FWD_DEPTH:0]             we_q, we_d;
    logic [FWD_DEPTH:0]             load_q, load_d;
    logic [FWD_DEPTH:0][REG_AW-1:0] rd_q, rd_d;
    logic [REG_AW-1:0]              rs1_q, rs1_d, rs2_q, rs2_d;
    logic                           use1_q, use1_d, use2_q, use2_d;

    logic [FWD_DEPTH:0] prod;
    logic               lu;
    logic               redir;
    logic               take;

    always_comb begin
        for (int k = 0; k <= FWD_DEPTH; k++) begin
            prod[k] = valid_q[k] && we_q[k] && (rd_q[k] != '0);
        end
    end

    // A load too young to forward its data holds D until it reaches LOAD_READY.
    always_comb begin
        lu = 1'b0;
        for (int j = 0; j <= FWD_DEPTH; j++) begin
            if ((j + 1 < LOAD_READY) && prod[j] && load_q[j] &&
                ((d_use1 && (d_rs1 == rd_q[j])) || (d_use2 && (d_rs2 == rd_q[j])))) begin
                lu = 1'b1;
            end
        end
        lu = lu && d_valid;
    end

    assign redir    = e_redirect && valid_q[0];
    assign take     = d_valid && !lu && !redir;
    assign stall_d  = ext_stall || (lu && !redir);
    assign flush_fd = redir && !ext_stall;
    assign e_valid  = valid_q[0];

    // Scan oldest to youngest so the youngest qualifying producer overwrites.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (valid_q[0] && prod[k] && (!load_q[k] || k >= LOAD_READY)) begin
                if (use1_q && (rd_q[k] == rs1_q)) fwd_sel1 = SELW'(k);
                if (use2_q && (rd_q[k] == rs2_q)) fwd_sel2 = SELW'(k);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        load_d  = load_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        use1_d  = use1_q;
        use2_d  = use2_q;
        if (!ext_stall) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                we_d[k]    = we_q[k-1];
                load_d[k]  = load_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
            valid_d[0] = take;
            we_d[0]    = take && d_we;
            load_d[0]  = take && d_load;
            rd_d[0]    = d_rd;
            rs1_d      = d_rs1;
            rs2_d      = d_rs2;
            use1_d     = take && d_use1;
            use2_d     = take && d_use2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            we_q    <= '0;
            load_q  <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            use1_q  <= 1'b0;
            use2_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            use1_q  <= use1_d;
            use2_q  <= use2_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(lu && !redir && !ext_stall);
        flush_cnt_d = flush_cnt_q + 32'(flush_fd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl: default-depth table plus a depth-3 load-use sequence.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;

    logic       a_dv, a_u1, a_u2, a_we, a_ld, a_redir, a_xs;
    logic [4:0] a_rs1, a_rs2, a_rd;
    logic       a_stall, a_flush, a_ev;
    logic [1:0] a_s1, a_s2;

    logic       b_dv, b_u1, b_u2, b_we, b_ld, b_redir, b_xs;
    logic [4:0] b_rs1, b_rs2, b_rd;
    logic       b_stall, b_flush, b_ev;
    logic [1:0] b_s1, b_s2;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    pipe_hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .d_valid(a_dv), .d_rs1(a_rs1), .d_rs2(a_rs2),
        .d_use1(a_u1), .d_use2(a_u2), .d_rd(a_rd), .d_we(a_we), .d_load(a_ld),
        .e_redirect(a_redir), .ext_stall(a_xs), .stall_d(a_stall), .flush_fd(a_flush),
        .e_valid(a_ev), .fwd_sel1(a_s1),
`ifdef PIPE_HAZARD_PERF_EN
        .fwd_sel2(a_s2), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`else
        .fwd_sel2(a_s2)
`endif
    );

    pipe_hazard_ctrl #(.FWD_DEPTH(3), .LOAD_READY(3)) dut_b (
        .clk(clk), .rst(rst), .d_valid(b_dv), .d_rs1(b_rs1), .d_rs2(b_rs2),
        .d_use1(b_u1), .d_use2(b_u2), .d_rd(b_rd), .d_we(b_we), .d_load(b_ld),
        .e_redirect(b_redir), .ext_stall(b_xs), .stall_d(b_stall), .flush_fd(b_flush),
        .e_valid(b_ev), .fwd_sel1(b_s1),
`ifdef PIPE_HAZARD_PERF_EN
        .fwd_sel2(b_s2), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`else
        .fwd_sel2(b_s2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       dv;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we, ld, redir, xs;
        logic       stall, flush, ev;
        logic [1:0] s1, s2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic dv, input int rs1, input logic u1,
                                input int rs2, input logic u2, input int rd,
                                input logic we, input logic ld, input logic redir, input logic xs,
                                input logic stall, input logic flush, input logic ev,
                                input int s1, input int s2);
        vec_t v;
        v.dv = dv; v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
        v.rd = 5'(rd); v.we = we; v.ld = ld; v.redir = redir; v.xs = xs;
        v.stall = stall; v.flush = flush; v.ev = ev; v.s1 = 2'(s1); v.s2 = 2'(s2);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input vec_t v);
        a_dv = v.dv; a_rs1 = v.rs1; a_u1 = v.u1; a_rs2 = v.rs2; a_u2 = v.u2;
        a_rd = v.rd; a_we = v.we; a_ld = v.ld; a_redir = v.redir; a_xs = v.xs;
    endtask

    task automatic drive_b(input logic dv, input int rs1, input int rd, input logic ld);
        b_dv = dv; b_rs1 = 5'(rs1); b_u1 = dv; b_rs2 = '0; b_u2 = 1'b0;
        b_rd = 5'(rd); b_we = dv; b_ld = ld; b_redir = 1'b0; b_xs = 1'b0;
    endtask

    // A load at a stage too young to forward must never be matched by E's sources.
    always @(negedge clk) begin
        if (!rst && dut_a.valid_q[0]) begin
            logic early;
            early = 1'b0;
            for (int k = 1; k < 2; k++) begin
                if (dut_a.valid_q[k] && dut_a.we_q[k] && dut_a.load_q[k] && dut_a.rd_q[k] != 0 &&
                    ((dut_a.use1_q && dut_a.rd_q[k] == dut_a.rs1_q) ||
                     (dut_a.use2_q && dut_a.rd_q[k] == dut_a.rs2_q)))
                    early = 1'b1;
            end
            checks++;
            if (early) begin
                fails++;
                $display("FAIL early_load_match: got 1, expected 0 at %0t", $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // columns: dv rs1 u1 rs2 u2 rd we ld redir xs | stall flush ev sel1 sel2
        tbl.push_back(mk(1, 1,1, 2,1, 5,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1, 5,1, 3,1, 6,1,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1, 5,1, 6,1, 7,1,0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,1,2,1));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1, 1,1, 0,0, 5,1,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1, 5,1, 0,0, 6,1,0,0,0, 1,0,1,0,0));
        tbl.push_back(mk(1, 5,1, 0,0, 6,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,1,2,0));
        tbl.push_back(mk(1, 1,1, 2,1, 8,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1, 3,1, 4,1, 8,1,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1, 0,1, 8,1, 9,1,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1, 9,1, 0,0, 0,1,0,0,0, 0,0,1,0,1));
        tbl.push_back(mk(1, 0,1, 0,1,10,1,0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1, 1,1, 0,0, 0,1,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1, 0,1, 0,0,11,1,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1, 1,1, 0,0,12,1,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,12,0,12,0,14,1,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1, 1,1, 0,0,13,1,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1, 0,0,13,1,15,1,0,0,0, 1,0,1,0,0));
        tbl.push_back(mk(1, 0,0,13,1,15,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,1,0,2));
        tbl.push_back(mk(1, 1,1, 0,0, 5,1,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1, 5,1, 0,0, 6,1,0,1,0, 0,1,1,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,1,0, 0,0,0,0,0));
        tbl.push_back(mk(1, 5,1, 0,0, 6,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1, 1,1, 2,1,20,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,20,1, 0,0,21,1,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1,20,1,21,1,22,1,0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(1,22,1, 0,0,23,1,0,0,1, 1,0,1,2,1));
        tbl.push_back(mk(1,22,1, 0,0,23,1,0,0,1, 1,0,1,2,1));
        tbl.push_back(mk(1,22,1, 0,0,23,1,0,1,1, 1,0,1,2,1));
        tbl.push_back(mk(1,22,1, 0,0,23,1,0,0,0, 0,0,1,2,1));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,1,1,0));

        // Reset with live random decode inputs: every output must stay low.
        rst = 1'b1;
        a_dv = 1'b1; a_rs1 = 5'($urandom_range(1, 31)); a_rs2 = 5'($urandom_range(1, 31));
        a_u1 = 1'($urandom); a_u2 = 1'($urandom); a_rd = 5'($urandom_range(1, 31));
        a_we = 1'($urandom); a_ld = 1'($urandom); a_redir = 1'b0; a_xs = 1'b0;
        drive_b(1'b0, 0, 0, 1'b0);
        #2;
        chk("rst a stall_d", int'(a_stall), 0);
        chk("rst a flush_fd", int'(a_flush), 0);
        chk("rst a e_valid", int'(a_ev), 0);
        chk("rst a fwd_sel1", int'(a_s1), 0);
        chk("rst a fwd_sel2", int'(a_s2), 0);
        chk("rst b e_valid", int'(b_ev), 0);
        chk("rst b fwd_sel1", int'(b_s1), 0);
`ifdef PIPE_HAZARD_PERF_EN
        chk("rst a stall_cnt", int'(a_stall_cnt), 0);
        chk("rst a flush_cnt", int'(a_flush_cnt), 0);
`endif
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post-rst e_valid before edge", int'(a_ev), 0);
        tick();
        chk("e_valid one cycle after d_valid", int'(a_ev), 1);
        rst = 1'b1;
        #1;
        chk("async rst clears e_valid", int'(a_ev), 0);
        tick();
        rst = 1'b0;
        drive_a(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,0,0,0));
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            drive_a(tbl[i]);
            #1;
            chk($sformatf("row%0d stall_d", i), int'(a_stall), int'(tbl[i].stall));
            chk($sformatf("row%0d flush_fd", i), int'(a_flush), int'(tbl[i].flush));
            chk($sformatf("row%0d e_valid", i), int'(a_ev), int'(tbl[i].ev));
            chk($sformatf("row%0d fwd_sel1", i), int'(a_s1), int'(tbl[i].s1));
            chk($sformatf("row%0d fwd_sel2", i), int'(a_s2), int'(tbl[i].s2));
            tick();
        end
        drive_a(mk(0, 0,0, 0,0, 0,0,0,0,0, 0,0,0,0,0));

        // Depth 3, load data ready at E+3: lw x5 then add using x5 costs two bubbles.
        drive_b(1'b1, 1, 5, 1'b1);
        #1;
        chk("b c0 stall_d", int'(b_stall), 0);
        tick();
        drive_b(1'b1, 5, 6, 1'b0);
        #1;
        chk("b c1 stall_d", int'(b_stall), 1);
        chk("b c1 e_valid", int'(b_ev), 1);
        tick();
        #1;
        chk("b c2 stall_d", int'(b_stall), 1);
        chk("b c2 e_valid", int'(b_ev), 0);
        tick();
        #1;
        chk("b c3 stall_d", int'(b_stall), 0);
        chk("b c3 e_valid", int'(b_ev), 0);
        tick();
        drive_b(1'b0, 0, 0, 1'b0);
        #1;
        chk("b c4 e_valid", int'(b_ev), 1);
        chk("b c4 fwd_sel1", int'(b_s1), 3);
        chk("b c4 fwd_sel2", int'(b_s2), 0);
        tick();

`ifdef PIPE_HAZARD_PERF_EN
        chk("a stall_cnt", int'(a_stall_cnt), 2);
        chk("a flush_cnt", int'(a_flush_cnt), 1);
        chk("b stall_cnt", int'(b_stall_cnt), 2);
        chk("b flush_cnt", int'(b_flush_cnt), 0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
